// File: rtl/commit_pkg.sv
// commit_pkg: shared definitions for the commit bus.
//   - RSID width and the reserved "no producer / idle bus" RSID.
//   - Write-enable and instruction-ID widths.
//   - Commit packet layout {RSID, tag, ID, WE, destination, data} for the
//     default bus geometry, its total width, and pack/unpack helpers that the
//     reservation stations use when snooping the bus.
package commit_pkg;

    localparam int RSID_W = 4;
    localparam logic [RSID_W-1:0] RSID_NONE = '0;
    localparam int WE_W = 3;
    localparam int ID_W = 4;

    localparam int PKT_TAG_W  = 4;
    localparam int PKT_ADDR_W = 16;
    localparam int PKT_DATA_W = 96;
    localparam int COMMIT_PKT_W = RSID_W + PKT_TAG_W + ID_W + WE_W + PKT_ADDR_W + PKT_DATA_W;

    typedef struct packed {
        logic [RSID_W-1:0]     rsid;
        logic [PKT_TAG_W-1:0]  tag;
        logic [ID_W-1:0]       id;
        logic [WE_W-1:0]       we;
        logic [PKT_ADDR_W-1:0] dest;
        logic [PKT_DATA_W-1:0] data;
    } commit_pkt_t;

    function automatic logic [COMMIT_PKT_W-1:0] pack_commit(input commit_pkt_t p);
        return p;
    endfunction

    function automatic commit_pkt_t unpack_commit(input logic [COMMIT_PKT_W-1:0] v);
        return commit_pkt_t'(v);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index where the search starts (must be < N)
//   en_i    : 0 forces an all-zero grant
//   grant_o : one-hot grant (all-zero when nothing is granted)
//   idx_o   : encoded index of the granted bit (0 when nothing is granted)
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Walk the requests starting at ptr_i with wrap-around; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % N);
            if (en_i && !found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/commit_bus_arbiter.sv
// commit_bus_arbiter: grants one reservation-station commit per cycle in
// round-robin order and drives the registered commit bus plus the
// register-file write port.
//   Clock / Reset        : single clock, asynchronous active-high reset
//   iCommitRequest       : per-station level request, held until granted
//   iId/iTag/iWE/
//   iDestination/iResult : per-station commit payload, flat, station i at slice i
//   iCommitHold          : blocks new grants in the same cycle
//   oCommitGranted       : combinational one-hot grant
//   oCommit*             : registered commit bus (RSID 0 when idle)
//   oRegWrite*           : register-file port, mirrors the commit bus
module commit_bus_arbiter
    import commit_pkg::*;
#(
    parameter int NUM_RS = 8,
    parameter int DATA_W = 96,
    parameter int ADDR_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_RS-1:0]          iCommitRequest,
    input  logic [NUM_RS*ID_W-1:0]     iId,
    input  logic [NUM_RS*TAG_W-1:0]    iTag,
    input  logic [NUM_RS*WE_W-1:0]     iWE,
    input  logic [NUM_RS*ADDR_W-1:0]   iDestination,
    input  logic [NUM_RS*DATA_W-1:0]   iResult,
    input  logic                       iCommitHold,
    output logic [NUM_RS-1:0]          oCommitGranted,
    output logic                       oCommitValid,
    output logic [RSID_W-1:0]          oCommitRsId,
    output logic [TAG_W-1:0]           oCommitTag,
    output logic [ID_W-1:0]            oCommitId,
    output logic [WE_W-1:0]            oCommitWE,
    output logic [ADDR_W-1:0]          oCommitDestination,
    output logic [DATA_W-1:0]          oCommitData,
    output logic                       oRegWrite,
    output logic [WE_W-1:0]            oRegWriteMask,
    output logic [ADDR_W-1:0]          oRegWriteAddress,
    output logic [DATA_W-1:0]          oRegWriteData
);

    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    // Per-station views of the flat payload buses.
    logic [ID_W-1:0]   st_id   [NUM_RS];
    logic [TAG_W-1:0]  st_tag  [NUM_RS];
    logic [WE_W-1:0]   st_we   [NUM_RS];
    logic [ADDR_W-1:0] st_dest [NUM_RS];
    logic [DATA_W-1:0] st_data [NUM_RS];

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_station
        assign st_id[gi]   = iId[gi*ID_W +: ID_W];
        assign st_tag[gi]  = iTag[gi*TAG_W +: TAG_W];
        assign st_we[gi]   = iWE[gi*WE_W +: WE_W];
        assign st_dest[gi] = iDestination[gi*ADDR_W +: ADDR_W];
        assign st_data[gi] = iResult[gi*DATA_W +: DATA_W];
    end

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              valid_q,  valid_d;
    logic [RSID_W-1:0] rsid_q,   rsid_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [ID_W-1:0]   id_q,     id_d;
    logic [WE_W-1:0]   we_q,     we_d;
    logic [ADDR_W-1:0] dest_q,   dest_d;
    logic [DATA_W-1:0] data_q,   data_d;

    logic [NUM_RS-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_grant;
    logic              arb_en;

    // Reset also suppresses the grant so no station sees a grant that the
    // bus register would then discard.
    assign arb_en = ~iCommitHold & ~Reset;

    rr_arbiter #(
        .N     (NUM_RS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (iCommitRequest),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign any_grant      = |grant;
    assign oCommitGranted = grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = 1'b0;
        rsid_d   = RSID_NONE;
        // Payload fields hold their last value on idle cycles.
        tag_d    = tag_q;
        id_d     = id_q;
        we_d     = we_q;
        dest_d   = dest_q;
        data_d   = data_q;
        if (any_grant) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
            valid_d  = 1'b1;
            rsid_d   = RSID_W'(grant_idx) + RSID_W'(1);
            tag_d    = st_tag[grant_idx];
            id_d     = st_id[grant_idx];
            we_d     = st_we[grant_idx];
            dest_d   = st_dest[grant_idx];
            data_d   = st_data[grant_idx];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            rsid_q   <= RSID_NONE;
            tag_q    <= '0;
            id_q     <= '0;
            we_q     <= '0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            rsid_q   <= rsid_d;
            tag_q    <= tag_d;
            id_q     <= id_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign oCommitValid       = valid_q;
    assign oCommitRsId        = rsid_q;
    assign oCommitTag         = tag_q;
    assign oCommitId          = id_q;
    assign oCommitWE          = we_q;
    assign oCommitDestination = dest_q;
    assign oCommitData        = data_q;

    // A WE=000 commit still goes on the bus for forwarding but never writes.
    assign oRegWrite        = valid_q & (|we_q);
    assign oRegWriteMask    = we_q;
    assign oRegWriteAddress = dest_q;
    assign oRegWriteData    = data_q;

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// tb_commit_bus_arbiter: directed stimulus for commit_bus_arbiter with a
// behavioural round-robin model checked every cycle, plus hand-computed
// literal expectations along the directed sequence.
module tb_commit_bus_arbiter;

    localparam int N = 8;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              iCommitHold;
    logic [N-1:0]      st_req;
    logic [3:0]        st_id   [N];
    logic [3:0]        st_tag  [N];
    logic [2:0]        st_we   [N];
    logic [15:0]       st_dest [N];
    logic [95:0]       st_data [N];

    logic [N*4-1:0]    f_id;
    logic [N*4-1:0]    f_tag;
    logic [N*3-1:0]    f_we;
    logic [N*16-1:0]   f_dest;
    logic [N*96-1:0]   f_data;

    logic [N-1:0]      oCommitGranted;
    logic              oCommitValid;
    logic [3:0]        oCommitRsId;
    logic [3:0]        oCommitTag;
    logic [3:0]        oCommitId;
    logic [2:0]        oCommitWE;
    logic [15:0]       oCommitDestination;
    logic [95:0]       oCommitData;
    logic              oRegWrite;
    logic [2:0]        oRegWriteMask;
    logic [15:0]       oRegWriteAddress;
    logic [95:0]       oRegWriteData;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    always_comb begin
        f_id = '0; f_tag = '0; f_we = '0; f_dest = '0; f_data = '0;
        for (int i = 0; i < N; i++) begin
            f_id[i*4 +: 4]     = st_id[i];
            f_tag[i*4 +: 4]    = st_tag[i];
            f_we[i*3 +: 3]     = st_we[i];
            f_dest[i*16 +: 16] = st_dest[i];
            f_data[i*96 +: 96] = st_data[i];
        end
    end

    commit_bus_arbiter #(
        .NUM_RS (N), .DATA_W (96), .ADDR_W (16), .TAG_W (4)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iCommitRequest     (st_req),
        .iId                (f_id),
        .iTag               (f_tag),
        .iWE                (f_we),
        .iDestination       (f_dest),
        .iResult            (f_data),
        .iCommitHold        (iCommitHold),
        .oCommitGranted     (oCommitGranted),
        .oCommitValid       (oCommitValid),
        .oCommitRsId        (oCommitRsId),
        .oCommitTag         (oCommitTag),
        .oCommitId          (oCommitId),
        .oCommitWE          (oCommitWE),
        .oCommitDestination (oCommitDestination),
        .oCommitData        (oCommitData),
        .oRegWrite          (oRegWrite),
        .oRegWriteMask      (oRegWriteMask),
        .oRegWriteAddress   (oRegWriteAddress),
        .oRegWriteData      (oRegWriteData)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The winner is the requester closest to the pointer going upward
    // (modular distance), nobody when held.
    function automatic int pick(input logic [N-1:0] req, input int ptr, input logic hold);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ((i - ptr + N) % N) < bestd) begin
                    bestd = (i - ptr + N) % N;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    int          m_rsid  = 0;
    logic [3:0]  m_tag   = '0;
    logic [3:0]  m_id    = '0;
    logic [2:0]  m_we    = '0;
    logic [15:0] m_dest  = '0;
    logic [95:0] m_data  = '0;

    always @(posedge Clock) begin
        int g;
        if (Reset) begin
            m_ptr = 0; m_valid = 1'b0; m_rsid = 0;
            m_tag = '0; m_id = '0; m_we = '0; m_dest = '0; m_data = '0;
        end else begin
            g = pick(st_req, m_ptr, iCommitHold);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_rsid  = g + 1;
                m_tag   = st_tag[g];
                m_id    = st_id[g];
                m_we    = st_we[g];
                m_dest  = st_dest[g];
                m_data  = st_data[g];
                m_ptr   = (g + 1) % N;
                $display("txn: grant station %0d rsid=%0d we=%b dest=%h", g, g + 1, st_we[g], st_dest[g]);
            end else begin
                m_valid = 1'b0;
                m_rsid  = 0;
            end
        end
    end

    // Compare process: mid-cycle, inputs and registered outputs are stable.
    always @(negedge Clock) begin
        int          g;
        logic [N-1:0] eg;
        g  = Reset ? -1 : pick(st_req, m_ptr, iCommitHold);
        eg = (g >= 0) ? (N'(1) << g) : '0;
        chk("cmp_grant", 128'(oCommitGranted), 128'(eg));
        chk("cmp_valid", 128'(oCommitValid), 128'(Reset ? 1'b0 : m_valid));
        chk("cmp_rsid",  128'(oCommitRsId),  128'(Reset ? 0 : m_rsid));
        chk("cmp_tag",   128'(oCommitTag),   128'(Reset ? 4'h0 : m_tag));
        chk("cmp_id",    128'(oCommitId),    128'(Reset ? 4'h0 : m_id));
        chk("cmp_we",    128'(oCommitWE),    128'(Reset ? 3'h0 : m_we));
        chk("cmp_dest",  128'(oCommitDestination), 128'(Reset ? 16'h0 : m_dest));
        chk("cmp_data",  128'(oCommitData),  128'(Reset ? 96'h0 : m_data));
        chk("cmp_regwrite", 128'(oRegWrite), 128'(!Reset && m_valid && (m_we != 3'b000)));
        chk("cmp_regmask",  128'(oRegWriteMask),    128'(Reset ? 3'h0 : m_we));
        chk("cmp_regaddr",  128'(oRegWriteAddress), 128'(Reset ? 16'h0 : m_dest));
        chk("cmp_regdata",  128'(oRegWriteData),    128'(Reset ? 96'h0 : m_data));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] eg;
        iCommitHold = 1'b0;
        st_req      = '0;
        for (int i = 0; i < N; i++) begin
            st_id[i]   = 4'(15 - i);
            st_tag[i]  = 4'(i + 2);
            st_we[i]   = (i == 4) ? 3'b000 : 3'b111;
            st_dest[i] = 16'(16'h0020 + i * 16'h0010);
            st_data[i] = {3{32'hA5A5A500 + 32'(i)}};
        end

        // Reset state; a request during reset must not be granted.
        st_req[3] = 1'b1;
        repeat (2) @(posedge Clock);
        #2;
        chk("reset_grant",    128'(oCommitGranted), 128'(0));
        chk("reset_valid",    128'(oCommitValid), 128'(0));
        chk("reset_rsid",     128'(oCommitRsId), 128'(0));
        chk("reset_data",     128'(oCommitData), 128'(0));
        chk("reset_regwrite", 128'(oRegWrite), 128'(0));
        st_req = '0;
        @(posedge Clock);
        #1 Reset = 1'b0;

        // Single request on station 2 (ptr 0 -> 3).
        st_req[2] = 1'b1;
        #1 chk("t1_grant", 128'(oCommitGranted), 128'(8'b0000_0100));
        step(); st_req[2] = 1'b0;
        #1;
        chk("t1_valid",    128'(oCommitValid), 128'(1));
        chk("t1_rsid",     128'(oCommitRsId), 128'(3));
        chk("t1_regwrite", 128'(oRegWrite), 128'(1));
        chk("t1_addr",     128'(oRegWriteAddress), 128'(16'h0040));
        chk("t1_data",     128'(oRegWriteData), 128'(96'hA5A5A502_A5A5A502_A5A5A502));
        step();
        chk("t1_idle_valid", 128'(oCommitValid), 128'(0));
        chk("t1_idle_rsid",  128'(oCommitRsId), 128'(0));
        chk("t1_held_addr",  128'(oCommitDestination), 128'(16'h0040));

        // Station 4 with WE=000 (ptr 3 -> 5).
        st_req[4] = 1'b1;
        #1 chk("we0_grant", 128'(oCommitGranted), 128'(8'b0001_0000));
        step(); st_req[4] = 1'b0;
        #1;
        chk("we0_valid",    128'(oCommitValid), 128'(1));
        chk("we0_rsid",     128'(oCommitRsId), 128'(5));
        chk("we0_regwrite", 128'(oRegWrite), 128'(0));

        // Station 5 alone moves the pointer to 6.
        st_req[5] = 1'b1;
        step(); st_req[5] = 1'b0;

        // ptr 6, requests on 2 and 7: 7 first, then wrap to 2.
        st_req[2] = 1'b1; st_req[7] = 1'b1;
        #1 chk("wrap_grant7", 128'(oCommitGranted), 128'(8'b1000_0000));
        step(); st_req[7] = 1'b0;
        #1;
        chk("wrap_grant2", 128'(oCommitGranted), 128'(8'b0000_0100));
        chk("wrap_rsid8",  128'(oCommitRsId), 128'(8));
        step(); st_req[2] = 1'b0;
        #1 chk("wrap_rsid3", 128'(oCommitRsId), 128'(3));

        // Station 7 alone brings the pointer back to 0, then one idle cycle.
        st_req[7] = 1'b1;
        step(); st_req[7] = 1'b0;
        step();

        // Hold for 3 cycles with stations 1 and 5 requesting.
        st_req[1] = 1'b1; st_req[5] = 1'b1; iCommitHold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_grant", 128'(oCommitGranted), 128'(0));
            step();
            chk("hold_valid", 128'(oCommitValid), 128'(0));
        end
        iCommitHold = 1'b0;
        #1 chk("hold_rel_grant1", 128'(oCommitGranted), 128'(8'b0000_0010));
        step(); st_req[1] = 1'b0;
        #1;
        chk("hold_rel_grant5", 128'(oCommitGranted), 128'(8'b0010_0000));
        chk("hold_rel_rsid2",  128'(oCommitRsId), 128'(2));
        step(); st_req[5] = 1'b0;
        #1 chk("hold_rel_rsid6", 128'(oCommitRsId), 128'(6));

        // Reset asserted while a commit is on the bus.
        st_req[3] = 1'b1;
        step(); st_req[3] = 1'b0;
        #1 chk("mid_valid_before", 128'(oCommitValid), 128'(1));
        chk("mid_rsid_before", 128'(oCommitRsId), 128'(4));
        Reset = 1'b1;
        #1;
        chk("mid_valid",    128'(oCommitValid), 128'(0));
        chk("mid_rsid",     128'(oCommitRsId), 128'(0));
        chk("mid_regwrite", 128'(oRegWrite), 128'(0));
        step();
        Reset  = 1'b0;
        st_req = '1;
        #1;
        // All stations request continuously: grants 0..7,0 back to back.
        for (int k = 0; k < 9; k++) begin
            eg = N'(1) << (k % N);
            chk("all_grant", 128'(oCommitGranted), 128'(eg));
            step();
            chk("all_valid", 128'(oCommitValid), 128'(1));
            chk("all_rsid",  128'(oCommitRsId), 128'((k % N) + 1));
            #1;
        end
        st_req = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_bus_arbiter.md
# commit_bus_arbiter

Arbitrates commit requests from up to `NUM_RS` reservation stations and grants one per cycle, round-robin. It drives the registered commit bus that all reservation stations snoop for dependency forwarding, and the register-file write port. It is the responder side of the station's request/grant handshake.

## Interface
- `NUM_RS`, 8: number of reservation stations, 1..15. Station index i carries RSID i+1; RSID 0 is reserved for "no producer / idle bus".
- `DATA_W`, 96: result row width (3×32 channels).
- `ADDR_W`, 16: destination address width.
- `TAG_W`, 4: issue tag width.
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `iCommitRequest` in NUM_RS: per-station request, level, held until granted.
- `iId` in NUM_RS×4: per-station instruction ID.
- `iTag` in NUM_RS×TAG_W: per-station tag.
- `iWE` in NUM_RS×3: per-station channel write mask.
- `iDestination` in NUM_RS×ADDR_W: per-station destination address.
- `iResult` in NUM_RS×DATA_W: per-station result.
- `iCommitHold` in 1: back-pressure; 1 blocks new grants.
- `oCommitGranted` out NUM_RS: one-hot grant, combinational.
- `oCommitValid` out 1: commit bus carries a result.
- `oCommitRsId` out 4: RSID of the producer; 0 when idle.
- `oCommitTag` out TAG_W: commit bus tag.
- `oCommitId` out 4: commit bus instruction ID.
- `oCommitWE` out 3: commit bus write mask.
- `oCommitDestination` out ADDR_W: commit bus destination.
- `oCommitData` out DATA_W: commit bus data.
- `oRegWrite` out 1: register-file write strobe.
- `oRegWriteMask` out 3: register-file channel mask.
- `oRegWriteAddress` out ADDR_W: register-file write address.
- `oRegWriteData` out DATA_W: register-file write data.

## Operation
- Grant is combinational:
  - `oCommitGranted` = round-robin pick among the asserted `iCommitRequest` bits.
  - Search starts at index `rr_ptr`.
  - Grant is forced to all-zero when `iCommitHold` = 1 or no request is asserted.
- Pointer update: on a cycle with a grant to index g, `rr_ptr` ← (g+1) mod NUM_RS. It is unchanged otherwise.
- Bus register: on a grant cycle, the granted station's {ID, tag, WE, destination, result} is registered.
  - `oCommitRsId` ← g+1; `oCommitValid` ← 1.
  - On a no-grant cycle: `oCommitValid` ← 0 and `oCommitRsId` ← 0. The data, tag, ID, WE and destination fields are held, not zeroed.
- Register-file port mirrors the bus register:
  - `oRegWrite` = `oCommitValid` & |`oCommitWE`.
  - Mask, address and data equal the corresponding bus fields.
  - A commit with WE=000 still appears on the bus (for forwarding) but does not write.
- Stations deassert or replace their request in the cycle after a grant. A request still asserted after its grant is treated as a new request.
- Invariants:
  - At most one grant bit is set.
  - A grant is never issued to a non-requesting station.
  - No station waits more than NUM_RS−1 grants once requesting.

## Timing
- Reset (async), all registers cleared:
  - `rr_ptr` = 0.
  - `oCommitValid`, `oCommitRsId`, `oCommitTag`, `oCommitId`, `oCommitWE`, `oCommitDestination` and `oCommitData` = 0.
  - `oRegWrite` = 0, and therefore the whole register-file port reads 0.
  - `oCommitGranted` is 0 while `Reset` is high, regardless of requests.
- Latency: request sampled and granted in cycle N; result on the commit bus and register-file port in cycle N+1, valid for exactly one cycle.
- Throughput: one commit per cycle. Back-to-back grants to different stations give consecutive valid bus cycles.
- `iCommitHold` takes effect in the same cycle: no grant in cycle N, bus idle in N+1. Requests remain pending and `rr_ptr` is unchanged.
- Simultaneous requests: lowest index at or after `rr_ptr` wins, with wrap-around from NUM_RS−1 to 0.
- Reset asserted mid-transfer:
  - An in-flight bus cycle is dropped.
  - The granted station must treat the grant as void; stations are reset on the same signal.
  - The first cycle after release starts again from `rr_ptr` = 0.

## Structure
- Shared package `commit_pkg`:
  - RSID width (4) and `RSID_NONE` = 0.
  - WE width (3).
  - Commit packet field order {RSID, tag, ID, WE, destination, data}, and its total-width constant.
  - Packing/unpacking functions used by the reservation stations.
- Sub-module `rr_arbiter`:
  - Parameter N.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
  - The pointer register lives in `commit_bus_arbiter`.

## Test plan
- Reset, then a request only on station 2 with WE=111, dest 0x0040, data 0xA5… → grant 0b00000100 in cycle 1. In cycle 2: valid=1, RsId=3, regWrite=1, addr 0x0040. In cycle 3: valid=0, RsId=0.
- All 8 stations request continuously from `rr_ptr`=0 → grants 0,1,…,7,0 on consecutive cycles; bus RsId sequence 1..8,1 with no idle cycles.
- Stations 1 and 5 request with `iCommitHold`=1 for 3 cycles → no grants and bus idle throughout. After hold drops: station 1 granted, then station 5, with pointer honoured.
- Station 4 commits with WE=000 → bus valid with RsId=5, `oRegWrite`=0.
- `rr_ptr`=6 with requests on 2 and 7 → station 7 first, then wrap-around to 2.
- Assert `Reset` in the cycle after a grant → bus valid, RsId and regWrite drop to 0 immediately (asynchronously). After release, an all-request pattern grants station 0 first.
